// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin share of one 1-cycle-latency sync sram.
// Ports: clk, rst_n (sync, active-low); per-requester req_i/we_i/addr_i/
//   wdata_i in, gnt_o (comb one-hot), rvalid_o + rdata_o read return;
//   sram_cs_o/sram_we_o/sram_addr_o/sram_din_o registered command,
//   sram_dout_i read data.
// Option: define ARB_BURST_LOCK_EN to let an owner hold priority for up
//   to MAX_BURST consecutive transfers.
module sram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          sram_cs_o,
  output logic                          sram_we_o,
  output logic [ADDR_WIDTH-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_din_o,
  input  logic [DATA_WIDTH-1:0]         sram_dout_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PW-1:0] idx_t;
  typedef logic [PW:0]   sum_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
    $error("sram_port_arbiter: parameter out of range");
  end

  function automatic idx_t nxt(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  idx_t                  ptr_q, ptr_d;
  idx_t                  win;
  sum_t                  cand;
  logic                  found;
  logic                  xfer;
  logic [NUM_REQ-1:0]    gnt;

  logic                  cs_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  // read tag pipeline: stage 1 = command on the sram port,
  // stage 2 = data on sram_dout
  logic                  t1_v_q, t2_v_q;
  idx_t                  t1_id_q, t2_id_q;

  // first requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + sum_t'(k);
      if (cand >= sum_t'(NUM_REQ)) cand = cand - sum_t'(NUM_REQ);
      if (!found && req_i[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    if (found && rst_n) gnt[win] = 1'b1;
  end

  assign gnt_o = gnt;
  assign xfer  = |gnt;

`ifdef ARB_BURST_LOCK_EN
  logic [3:0] cnt_q, cnt_d, cnt_nx;

  // a nonzero count means ptr_q is the current burst owner
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    cnt_nx = (cnt_q != 4'd0 && win == ptr_q) ? cnt_q + 4'd1 : 4'd1;
    if (xfer) begin
      if (cnt_nx >= 4'(MAX_BURST)) begin
        ptr_d = nxt(win);
        cnt_d = 4'd0;
      end else begin
        ptr_d = win;
        cnt_d = cnt_nx;
      end
    end else if (cnt_q != 4'd0) begin
      ptr_d = nxt(ptr_q);
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    ptr_d = xfer ? nxt(win) : ptr_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      t1_v_q  <= 1'b0;
      t1_id_q <= '0;
      t2_v_q  <= 1'b0;
      t2_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cs_q  <= xfer;
      we_q  <= xfer & we_i[win];
      if (xfer) begin
        addr_q <= addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        din_q  <= wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
      end
      t1_v_q  <= xfer & ~we_i[win];
      t1_id_q <= win;
      t2_v_q  <= t1_v_q;
      t2_id_q <= t1_id_q;
    end
  end

  assign sram_cs_o   = cs_q;
  assign sram_we_o   = we_q;
  assign sram_addr_o = addr_q;
  assign sram_din_o  = din_q;
  assign rvalid_o    = t2_v_q ? (NUM_REQ'(1) << t2_id_q) : '0;
  assign rdata_o     = sram_dout_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: random + directed bench for sram_port_arbiter.
// Holds a behavioural sram and a queue-based reference model.
module tb_sram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req, we, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, sram_din, sram_dout;
  logic [AW-1:0]   sram_addr;
  logic            sram_cs, sram_we;

  sram_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_din_o(sram_din),
    .sram_dout_i(sram_dout)
  );

  function automatic logic [DW-1:0] init_val(input int k);
    if (k == 5) return 8'hA3;
    return DW'((k * 37 + 11) & 255);
  endfunction

  // behavioural sram, 1-cycle read latency
  logic [DW-1:0] smem [16];
  logic          s_init = 1'b0;
  always @(posedge clk) begin
    if (!s_init) begin
      for (int k = 0; k < 16; k++) smem[k] <= init_val(k);
      s_init <= 1'b1;
    end else if (sram_cs === 1'b1) begin
      if (sram_we) smem[sram_addr] <= sram_din;
      else         sram_dout <= smem[sram_addr];
    end
  end

  // reference model state
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] mmem [16];
  int            mptr, mcnt, cyc, last_w;
  bit            mvalid;
  logic          e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  int            total, bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic [N-1:0] w, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d);
    logic [N-1:0]  eg, erv;
    logic [DW-1:0] edat;
    int            win, run;
    @(negedge clk);
    rst_n = r; req = rq; we = w; addr = a; wdata = d;
    #1;
    win = -1;
    if (r) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && rq[(mptr + k) % N]) win = (mptr + k) % N;
      end
    end
    if (mvalid) begin
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      erv  = '0;
      edat = '0;
      foreach (pend[j]) begin
        if (pend[j].due == cyc) begin
          erv[pend[j].id] = 1'b1;
          edat = pend[j].data;
        end
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("sram_cs", 32'(sram_cs), 32'(e_cs));
      chk("sram_we", 32'(sram_we), 32'(e_we));
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("sram_din", 32'(sram_din), 32'(e_din));
      chk("rvalid", 32'(rvalid), 32'(erv));
      if (erv != '0) chk("rdata", 32'(rdata), 32'(edat));
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    last_w = win;
    if (!r) begin
      mptr = 0; mcnt = 0; pend.delete();
      e_cs = 0; e_we = 0; e_addr = '0; e_din = '0;
      mvalid = 1'b1;
    end else begin
      if (win >= 0) begin
        e_cs   = 1'b1;
        e_we   = w[win];
        e_addr = a[win*AW +: AW];
        e_din  = d[win*DW +: DW];
        if (w[win]) mmem[e_addr] = e_din;
        else pend.push_back('{due: cyc + 2, id: win, data: mmem[e_addr]});
      end else begin
        e_cs = 1'b0;
        e_we = 1'b0;
      end
`ifdef ARB_BURST_LOCK_EN
      if (win >= 0) begin
        run = (mcnt > 0 && win == mptr) ? mcnt + 1 : 1;
        if (run >= MB) begin mptr = (win + 1) % N; mcnt = 0; end
        else begin mptr = win; mcnt = run; end
      end else if (mcnt > 0) begin
        mptr = (mptr + 1) % N;
        mcnt = 0;
      end
`else
      run = 0;
      if (win >= 0) mptr = (win + run + 1) % N;
`endif
    end
    cyc++;
  endtask

  logic [N-1:0]    rq, wq;
  logic [N*AW-1:0] aq;
  logic [N*DW-1:0] dq;
  logic [N-1:0]    seq [4];

  initial begin
    total = 0; bad = 0; cyc = 0; mptr = 0; mcnt = 0;
    mvalid = 1'b0; last_w = -1;
    e_cs = 0; e_we = 0; e_addr = '0; e_din = '0;
    for (int k = 0; k < 16; k++) mmem[k] = init_val(k);
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;

    // reset with all requesting
    aq = {4'd3, 4'd2, 4'd1};
    step(0, 3'b111, 3'b000, aq, '0);
    step(0, 3'b111, 3'b000, aq, '0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_cs", 32'(sram_cs), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
`ifdef ARB_BURST_LOCK_EN
    seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    for (int i = 0; i < 4; i++) begin
      step(1, 3'b111, 3'b000, aq, '0);
      chk("rot_gnt", 32'(gnt), 32'(seq[i]));
    end

    // requester 1 reads word 5
    step(1, 3'b010, 3'b000, {4'd0, 4'd5, 4'd0}, '0);
    chk("rd5_gnt", 32'(gnt), 32'b010);
    step(1, 3'b000, 3'b000, '0, '0);
    chk("rd5_cs", 32'(sram_cs), 1);
    chk("rd5_addr", 32'(sram_addr), 5);
    chk("rd5_we", 32'(sram_we), 0);
    step(1, 3'b000, 3'b000, '0, '0);
    chk("rd5_rvalid", 32'(rvalid), 32'b010);
    chk("rd5_rdata", 32'(rdata), 32'hA3);

    // requester 0 writes, requester 2 reads it back
    step(1, 3'b001, 3'b001, {4'd0, 4'd0, 4'd2}, {8'h0, 8'h0, 8'h3C});
    chk("wr_gnt", 32'(gnt), 32'b001);
    step(1, 3'b100, 3'b000, {4'd2, 4'd0, 4'd0}, '0);
    step(1, 3'b000, 3'b000, '0, '0);
    chk("wr_norv", 32'(rvalid), 0);
    step(1, 3'b000, 3'b000, '0, '0);
    chk("rb_rvalid", 32'(rvalid), 32'b100);
    chk("rb_rdata", 32'(rdata), 32'h3C);

    // single requester streams back-to-back
    for (int i = 0; i < 5; i++) begin
      step(1, 3'b100, 3'b000, {AW'(i + 8), 4'd0, 4'd0}, '0);
      chk("solo_gnt", 32'(gnt), 32'b100);
      if (i > 0) chk("solo_cs", 32'(sram_cs), 1);
    end
    step(1, 3'b011, 3'b000, {4'd0, 4'd1, 4'd4}, '0);
    chk("wrap_gnt", 32'(gnt), 32'b001);
    chk("solo_cs5", 32'(sram_cs), 1);
    chk("solo_addr5", 32'(sram_addr), 12);

    // reset right after a read is accepted
    step(1, 3'b010, 3'b000, {4'd0, 4'd7, 4'd0}, '0);
    step(0, 3'b000, 3'b000, '0, '0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    step(1, 3'b000, 3'b000, '0, '0);
    chk("mid_rst_cs", 32'(sram_cs), 0);
    chk("mid_rst_rv", 32'(rvalid), 0);
    step(1, 3'b000, 3'b000, '0, '0);
    chk("mid_rst_rv2", 32'(rvalid), 0);

`ifdef ARB_BURST_LOCK_EN
    step(0, 3'b000, 3'b000, '0, '0);
    for (int i = 0; i < 12; i++) begin
      step(1, 3'b111, 3'b000, aq, '0);
      chk("burst_gnt", 32'(gnt), 32'(1 << (i / 4)));
    end
    step(0, 3'b000, 3'b000, '0, '0);
    step(1, 3'b111, 3'b000, aq, '0);
    step(1, 3'b111, 3'b000, aq, '0);
    step(1, 3'b110, 3'b000, aq, '0);
    chk("burst_drop", 32'(gnt), 32'b010);
`endif

    // randomized traffic honouring the hold-until-accepted rule
    rq = '0; wq = '0; aq = '0; dq = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i] && last_w != i) begin
          if ($urandom_range(0, 19) == 0) rq[i] = 1'b0;
        end else begin
          rq[i] = ($urandom_range(0, 9) < 6);
          wq[i] = 1'($urandom_range(0, 1));
          aq[i*AW +: AW] = AW'($urandom_range(0, 15));
          dq[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
      end
      step(($urandom_range(0, 99) != 0), rq, wq, aq, dq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
